// File: rtl/text_console_pkg.sv
// Shared geometry, character constants and FSM state type for the text console.
package text_console_pkg;

    localparam int unsigned COLS  = 80;
    localparam int unsigned ROWS  = 30;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = 12;
    localparam int unsigned CNTW  = 13;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor col/row registers with a registered linear address and a row-wrap flag.
import text_console_pkg::*;

module console_cursor #(
    parameter int unsigned NCOLS = COLS,
    parameter int unsigned NROWS = ROWS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_advance,
    input  logic                      op_newline,
    input  logic                      op_return,
    input  logic                      op_back,
    input  logic                      op_zero,
    output logic [$clog2(NCOLS)-1:0]  col,
    output logic [$clog2(NROWS)-1:0]  row,
    output logic [AW-1:0]             addr,
    output logic                      wrap_c
);

    localparam int unsigned CW = $clog2(NCOLS);
    localparam int unsigned RW = $clog2(NROWS);

    logic [CW-1:0] col_n;
    logic [RW-1:0] row_n;
    logic          last_col;
    logic          last_row;

    assign last_col = (col == CW'(NCOLS - 1));
    assign last_row = (row == RW'(NROWS - 1));
    assign wrap_c   = last_row && ((op_advance && last_col) || op_newline);

    // Zero has priority; the remaining ops are mutually exclusive from the decoder.
    always_comb begin
        col_n = col;
        row_n = row;
        if (op_zero) begin
            col_n = '0;
            row_n = '0;
        end else if (op_advance) begin
            if (last_col) begin
                col_n = '0;
                row_n = last_row ? '0 : row + RW'(1);
            end else begin
                col_n = col + CW'(1);
            end
        end else if (op_newline) begin
            col_n = '0;
            row_n = last_row ? '0 : row + RW'(1);
        end else if (op_return) begin
            col_n = '0;
        end else if (op_back) begin
            if (col == '0) begin
                col_n = CW'(NCOLS - 1);
                row_n = row - RW'(1);
            end else begin
                col_n = col - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else begin
            col  <= col_n;
            row  <= row_n;
            addr <= AW'(row_n) * AW'(NCOLS) + AW'(col_n);
        end
    end

endmodule

// File: rtl/text_console.sv
// Byte-stream front end for the 80x30 text RAM: decode, cursor tracking, screen clear.
// Optional TEXT_CONSOLE_WRAP_CLEAR_EN: wrapping past the last row clears the screen.
import text_console_pkg::*;

module text_console (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    char_in,
    input  logic          char_valid,
    output logic          char_ready,
    output logic [AW-1:0] w_addr,
    output logic [7:0]    w_data,
    output logic          w_en,
    output logic [AW-1:0] cursor_addr,
    output logic          busy
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic            w_en_n;
    logic [AW-1:0]   w_addr_n;
    logic [7:0]      w_data_n;
    logic            accept;
    logic            printable;
    logic            op_advance, op_newline, op_return, op_back, op_zero;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            wrap_c;
    logic            clear_done;

    assign accept     = char_valid && char_ready;
    assign printable  = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign clear_done = (cnt == CNTW'(CELLS));

    console_cursor #(.NCOLS(COLS), .NROWS(ROWS)) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .op_advance (op_advance),
        .op_newline (op_newline),
        .op_return  (op_return),
        .op_back    (op_back),
        .op_zero    (op_zero),
        .col        (col),
        .row        (row),
        .addr       (cursor_addr),
        .wrap_c     (wrap_c)
    );

    // Byte decode and write-port sequencing.
    always_comb begin
        op_advance = 1'b0;
        op_newline = 1'b0;
        op_return  = 1'b0;
        op_back    = 1'b0;
        op_zero    = 1'b0;
        w_en_n     = 1'b0;
        w_addr_n   = w_addr;
        w_data_n   = w_data;
        if (state == CLEAR) begin
            if (clear_done) begin
                op_zero = 1'b1;
            end else begin
                w_en_n   = 1'b1;
                w_addr_n = cnt[AW-1:0];
                w_data_n = SPACE;
            end
        end else if (accept) begin
            if (printable) begin
                w_en_n     = 1'b1;
                w_addr_n   = cursor_addr;
                w_data_n   = char_in;
                op_advance = 1'b1;
            end else begin
                case (char_in)
                    LF: op_newline = 1'b1;
                    CR: op_return  = 1'b1;
                    BS: begin
                        if ((col != '0) || (row != '0)) begin
                            op_back  = 1'b1;
                            w_en_n   = 1'b1;
                            w_addr_n = cursor_addr - AW'(1);
                            w_data_n = SPACE;
                        end
                    end
                    FF: begin
                        w_en_n   = 1'b1;
                        w_addr_n = '0;
                        w_data_n = SPACE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FF's first clear write is issued on acceptance, so its counter starts at 1;
    // a wrap-triggered clear starts one cycle later from 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept && !printable && (char_in == FF)) begin
                    state_n = CLEAR;
                    cnt_n   = CNTW'(1);
                end
`ifdef TEXT_CONSOLE_WRAP_CLEAR_EN
                else if (wrap_c) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
`endif
            end
            CLEAR: begin
                if (clear_done) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            w_en       <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            char_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            w_en       <= w_en_n;
            w_addr     <= w_addr_n;
            w_data     <= w_data_n;
            char_ready <= (state_n == IDLE);
            busy       <= (state_n == CLEAR);
        end
    end

`ifndef TEXT_CONSOLE_WRAP_CLEAR_EN
    logic unused_wrap;
    assign unused_wrap = wrap_c;
`endif

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console.
module tb_text_console;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [11:0] w_addr;
    logic [7:0]  w_data;
    logic        w_en;
    logic [11:0] cursor_addr;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int wr_count   = 0;
    int hi_writes  = 0;
    bit watch      = 1'b0;

    always #5 clk = ~clk;

    text_console dut (
        .clk         (clk),
        .rst         (rst),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .w_en        (w_en),
        .cursor_addr (cursor_addr),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (w_en) begin
            wr_count++;
            if (watch && w_addr >= 12'd1000) hi_writes++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        char_in    = b;
        char_valid = 1'b1;
        step();
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!char_ready && n < 3000) begin
            step();
            n++;
        end
        check(tag, 32'(char_ready), 32'd1);
    endtask

    initial begin
        int bad;
        int snap;
        int n;
        rst        = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_w_en",   32'(w_en), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_cursor", 32'(cursor_addr), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_ready",  32'(char_ready), 32'd1);

        send(8'h41);
        check("A_w_en",   32'(w_en), 32'd1);
        check("A_w_addr", 32'(w_addr), 32'd0);
        check("A_w_data", 32'(w_data), 32'h41);
        check("A_cursor", 32'(cursor_addr), 32'd1);

        for (int i = 0; i < 78; i++) send(8'h2E);
        check("fill_cursor", 32'(cursor_addr), 32'd79);

        send(8'h42);
        check("B79_w_addr", 32'(w_addr), 32'd79);
        check("B79_w_data", 32'(w_data), 32'h42);
        check("B79_cursor", 32'(cursor_addr), 32'd80);

        send(8'h08);
        check("BS80_w_en",   32'(w_en), 32'd1);
        check("BS80_w_addr", 32'(w_addr), 32'd79);
        check("BS80_w_data", 32'(w_data), 32'h20);
        check("BS80_cursor", 32'(cursor_addr), 32'd79);

        send(8'h42);
        check("B79b_cursor", 32'(cursor_addr), 32'd80);
        send(8'h0A);
        check("LF_w_en",   32'(w_en), 32'd0);
        check("LF_cursor", 32'(cursor_addr), 32'd160);

        send(8'h78);
        check("x_w_addr", 32'(w_addr), 32'd160);
        check("x_cursor", 32'(cursor_addr), 32'd161);
        send(8'h0D);
        check("CR_w_en",   32'(w_en), 32'd0);
        check("CR_cursor", 32'(cursor_addr), 32'd160);
        send(8'h07);
        check("ign07_w_en",   32'(w_en), 32'd0);
        check("ign07_cursor", 32'(cursor_addr), 32'd160);
        send(8'h7F);
        check("ign7F_w_en",   32'(w_en), 32'd0);
        check("ign7F_cursor", 32'(cursor_addr), 32'd160);

        // FF followed by a held 'Z' that must wait out the clear.
        send(8'h0C);
        char_in    = 8'h5A;
        char_valid = 1'b1;
        check("FF_busy", 32'(busy), 32'd1);
        bad = 0;
        for (int i = 0; i < 2400; i++) begin
            if (!(w_en === 1'b1 && w_addr === 12'(i) && w_data === 8'h20 && char_ready === 1'b0))
                bad++;
            step();
        end
        check("clear_bad_cycles", 32'(bad), 32'd0);
        check("clear_end_w_en",   32'(w_en), 32'd0);
        check("clear_end_ready",  32'(char_ready), 32'd1);
        check("clear_end_busy",   32'(busy), 32'd0);
        check("clear_end_cursor", 32'(cursor_addr), 32'd0);
        step();
        char_valid = 1'b0;
        check("Z_w_en",   32'(w_en), 32'd1);
        check("Z_w_addr", 32'(w_addr), 32'd0);
        check("Z_w_data", 32'(w_data), 32'h5A);
        check("Z_cursor", 32'(cursor_addr), 32'd1);

        send(8'h0C);
        wait_idle("ff2_idle");
        send(8'h08);
        check("BS0_w_en",   32'(w_en), 32'd0);
        check("BS0_cursor", 32'(cursor_addr), 32'd0);

        for (int i = 0; i < 29; i++) send(8'h0A);
        check("row29_cursor", 32'(cursor_addr), 32'd2320);
        for (int i = 0; i < 79; i++) send(8'h2D);
        check("last_cursor", 32'(cursor_addr), 32'd2399);
        send(8'h41);
        check("last_w_en",   32'(w_en), 32'd1);
        check("last_w_addr", 32'(w_addr), 32'd2399);
        check("last_w_data", 32'(w_data), 32'h41);
        check("last_cursor_wrap", 32'(cursor_addr), 32'd0);
        step();
        snap = wr_count;
`ifdef TEXT_CONSOLE_WRAP_CLEAR_EN
        check("wrapclr_busy", 32'(busy), 32'd1);
        wait_idle("wrapclr_idle");
        check("wrapclr_writes", 32'(wr_count - snap), 32'd2400);
        check("wrapclr_cursor", 32'(cursor_addr), 32'd0);
`else
        check("wrap_busy",   32'(busy), 32'd0);
        check("wrap_w_en",   32'(w_en), 32'd0);
        check("wrap_cursor", 32'(cursor_addr), 32'd0);
`endif

        // Reset aborts a clear before address 1000 is written.
        watch = 1'b1;
        send(8'h0C);
        n = 0;
        while (!(w_en === 1'b1 && w_addr === 12'd999) && n < 3000) begin
            step();
            n++;
        end
        check("abort_reached_999", 32'(w_addr), 32'd999);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_w_en",   32'(w_en), 32'd0);
        check("abort_cursor", 32'(cursor_addr), 32'd0);
        check("abort_ready",  32'(char_ready), 32'd1);
        check("abort_busy",   32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("abort_quiet_w_en", 32'(w_en), 32'd0);
        check("abort_hi_writes",  32'(hi_writes), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
